// File: rtl/jzjpcc_mem_pkg.sv
// Shared definitions for the SRAM access controller.
//   - funct3 size field encodings
//   - controller state encoding
//   - sizeBytes(): access size in bytes from the funct3 size field
//   - isIllegal(): request legality check
package jzjpcc_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRST,
        ST_SECOND,
        ST_RESP
    } state_t;

    // Byte count of an access. The reserved encoding 11 maps to 4, but such
    // requests are rejected before any SRAM cycle is issued.
    function automatic logic [2:0] sizeBytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

    // Reserved size, or a store that asks for the unsigned variant.
    function automatic logic isIllegal(input logic write, input logic [2:0] funct3);
        return (funct3[1:0] == 2'b11) || (write && funct3[2]);
    endfunction

endpackage

// File: rtl/jzjpcc_lane_align.sv
// Purely combinational byte-lane alignment for one load/store.
//   off         in   byte offset inside the first word
//   n           in   access size in bytes (1, 2 or 4)
//   is_unsigned in   zero-extend (1) or sign-extend (0) loads
//   write_data  in   right-aligned store data
//   read_pair   in   {word w1, word w0} as returned by the SRAM
//   mask8       out  byte-lane mask across the two-word window
//   data64      out  store data shifted into lane position
//   load_data   out  extracted and extended load result
module jzjpcc_lane_align (
    input  logic [1:0]  off,
    input  logic [2:0]  n,
    input  logic        is_unsigned,
    input  logic [31:0] write_data,
    input  logic [63:0] read_pair,
    output logic [7:0]  mask8,
    output logic [63:0] data64,
    output logic [31:0] load_data
);

    logic [7:0]  base_mask;
    logic [31:0] shifted;

    // NOTE: every output of this always_comb is assigned on every path
    // (the case has a default) so no latch can be inferred.
    always_comb begin
        base_mask = (8'd1 << n) - 8'd1;
        mask8     = base_mask << off;
        data64    = {32'd0, write_data} << {off, 3'b000};
        shifted   = 32'(read_pair >> {off, 3'b000});
        case (n)
            3'd1:    load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            3'd2:    load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/jzjpcc_sram_access_controller.sv
// Load/store front end for one port of the byte-masked 32-bit SRAM
// (1-cycle registered read). Word-crossing accesses become two SRAM cycles.
//   clock, reset        clock and asynchronous active-high reset
//   reqValid/reqReady   request handshake (ready only while idle)
//   reqWrite            1 = store, 0 = load
//   reqFunct3           RISC-V funct3 (size in [1:0], unsigned in [2])
//   reqAddress          byte address
//   reqWriteData        right-aligned store data
//   respValid           single-cycle completion pulse
//   respReadData        extended load data (0 for stores and errors)
//   respError           illegal funct3, qualified by respValid
//   sramAddress         SRAM word address
//   sramWriteEnable     SRAM write enable
//   sramByteWriteMask   per-lane write mask
//   sramWrite           lane-aligned write data
//   sramRead            SRAM read data, valid the cycle after the address
module jzjpcc_sram_access_controller
    import jzjpcc_mem_pkg::*;
#(
    parameter int RAM_A_WIDTH = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   reqValid,
    output logic                   reqReady,
    input  logic                   reqWrite,
    input  logic [2:0]             reqFunct3,
    input  logic [31:0]            reqAddress,
    input  logic [31:0]            reqWriteData,
    output logic                   respValid,
    output logic [31:0]            respReadData,
    output logic                   respError,
    output logic [RAM_A_WIDTH-1:0] sramAddress,
    output logic                   sramWriteEnable,
    output logic [3:0]             sramByteWriteMask,
    output logic [31:0]            sramWrite,
    input  logic [31:0]            sramRead
);

    state_t                 state;
    logic                   write_q;
    logic                   unsigned_q;
    logic                   split_q;
    logic                   error_q;
    logic [1:0]             off_q;
    logic [2:0]             n_q;
    logic [RAM_A_WIDTH-1:0] w0_q;
    logic [31:0]            wdata_q;
    logic [31:0]            low_q;

    // Address bits above the SRAM window are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^reqAddress[31:RAM_A_WIDTH+2];

    // Decode of the incoming request, used on the accept edge.
    logic                   is_idle;
    logic [1:0]             in_off;
    logic [2:0]             in_n;
    logic                   in_split;
    logic                   in_illegal;

    assign is_idle    = (state == ST_IDLE);
    assign reqReady   = is_idle;
    assign in_off     = reqAddress[1:0];
    assign in_n       = sizeBytes(reqFunct3[1:0]);
    assign in_split   = ({2'b00, in_off} + {1'b0, in_n}) > 4'd4;
    assign in_illegal = isIllegal(reqWrite, reqFunct3);

    // The aligner sees the live request while idle (so the first SRAM cycle
    // can be registered on the accept edge) and the latched one afterwards.
    logic [1:0]  align_off;
    logic [2:0]  align_n;
    logic [31:0] align_wdata;
    logic [7:0]  mask8;
    logic [63:0] data64;
    logic [31:0] load_data;

    assign align_off   = is_idle ? in_off       : off_q;
    assign align_n     = is_idle ? in_n         : n_q;
    assign align_wdata = is_idle ? reqWriteData : wdata_q;

    jzjpcc_lane_align u_align (
        .off         (align_off),
        .n           (align_n),
        .is_unsigned (unsigned_q),
        .write_data  (align_wdata),
        .read_pair   ({sramRead, split_q ? low_q : sramRead}),
        .mask8       (mask8),
        .data64      (data64),
        .load_data   (load_data)
    );

    // The SRAM read of the last issued word lands during RESP, so the load
    // result is formed combinationally there instead of being registered.
    assign respReadData = (state == ST_RESP && !write_q && !error_q) ? load_data : 32'd0;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= ST_IDLE;
            write_q           <= 1'b0;
            unsigned_q        <= 1'b0;
            split_q           <= 1'b0;
            error_q           <= 1'b0;
            off_q             <= 2'd0;
            n_q               <= 3'd0;
            w0_q              <= '0;
            wdata_q           <= 32'd0;
            low_q             <= 32'd0;
            respValid         <= 1'b0;
            respError         <= 1'b0;
            sramAddress       <= '0;
            sramWriteEnable   <= 1'b0;
            sramByteWriteMask <= 4'd0;
            sramWrite         <= 32'd0;
        end else begin
            // SRAM port is quiet and no response is flagged unless a state
            // below says otherwise.
            respValid         <= 1'b0;
            respError         <= 1'b0;
            sramAddress       <= '0;
            sramWriteEnable   <= 1'b0;
            sramByteWriteMask <= 4'd0;
            sramWrite         <= 32'd0;

            case (state)
                ST_IDLE: begin
                    if (reqValid) begin
                        write_q    <= reqWrite;
                        unsigned_q <= reqFunct3[2];
                        split_q    <= in_split;
                        error_q    <= in_illegal;
                        off_q      <= in_off;
                        n_q        <= in_n;
                        w0_q       <= reqAddress[RAM_A_WIDTH+1:2];
                        wdata_q    <= reqWriteData;
                        if (in_illegal) begin
                            state     <= ST_RESP;
                            respValid <= 1'b1;
                            respError <= 1'b1;
                        end else begin
                            state             <= ST_FIRST;
                            sramAddress       <= reqAddress[RAM_A_WIDTH+1:2];
                            sramWriteEnable   <= reqWrite;
                            sramByteWriteMask <= mask8[3:0];
                            sramWrite         <= data64[31:0];
                        end
                    end
                end

                ST_FIRST: begin
                    if (split_q) begin
                        // Word address wraps naturally at the top of the SRAM.
                        state             <= ST_SECOND;
                        sramAddress       <= w0_q + {{(RAM_A_WIDTH-1){1'b0}}, 1'b1};
                        sramWriteEnable   <= write_q;
                        sramByteWriteMask <= mask8[7:4];
                        sramWrite         <= data64[63:32];
                    end else begin
                        state     <= ST_RESP;
                        respValid <= 1'b1;
                    end
                end

                ST_SECOND: begin
                    // sramRead now holds word w0; w1 arrives during RESP.
                    low_q     <= sramRead;
                    state     <= ST_RESP;
                    respValid <= 1'b1;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jzjpcc_sram_access_controller.sv
// Self-checking bench: table of directed vectors, a reset-during-split case
// and randomized traffic against a byte-array reference model.
module tb_jzjpcc_sram_access_controller;

    localparam int AW     = 12;
    localparam int NWORDS = 1 << AW;
    localparam int NBYTES = 4 * NWORDS;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [2:0]  reqFunct3;
    logic [31:0] reqAddress;
    logic [31:0] reqWriteData;
    logic        respValid;
    logic [31:0] respReadData;
    logic        respError;
    logic [AW-1:0] sramAddress;
    logic        sramWriteEnable;
    logic [3:0]  sramByteWriteMask;
    logic [31:0] sramWrite;
    logic [31:0] sramRead;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    jzjpcc_sram_access_controller #(.RAM_A_WIDTH(AW)) dut (
        .clock             (clock),
        .reset             (reset),
        .reqValid          (reqValid),
        .reqReady          (reqReady),
        .reqWrite          (reqWrite),
        .reqFunct3         (reqFunct3),
        .reqAddress        (reqAddress),
        .reqWriteData      (reqWriteData),
        .respValid         (respValid),
        .respReadData      (respReadData),
        .respError         (respError),
        .sramAddress       (sramAddress),
        .sramWriteEnable   (sramWriteEnable),
        .sramByteWriteMask (sramByteWriteMask),
        .sramWrite         (sramWrite),
        .sramRead          (sramRead)
    );

    // Byte-masked SRAM with 1-cycle registered read (old data on collision).
    logic [31:0] sram_mem [0:NWORDS-1] = '{default: 32'd0};
    always @(posedge clock) begin
        if (sramWriteEnable) begin
            for (int k = 0; k < 4; k++)
                if (sramByteWriteMask[k])
                    sram_mem[sramAddress][8*k +: 8] <= sramWrite[8*k +: 8];
        end
        sramRead <= sram_mem[sramAddress];
    end

    // Reference model: flat little-endian byte memory.
    logic [7:0] ref_mem [0:NBYTES-1] = '{default: 8'd0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // A write cycle must always carry at least one lane.
    always @(negedge clock)
        if (sramWriteEnable === 1'b1)
            check("we_mask_nonzero", 64'(sramByteWriteMask != 4'd0), 64'd1);

    function automatic int model_n(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit model_illegal(input logic w, input logic [2:0] f3);
        return (f3[1:0] == 2'b11) || (w && f3[2]);
    endfunction

    function automatic int model_lat(input logic w, input logic [2:0] f3, input logic [31:0] a);
        if (model_illegal(w, f3)) return 1;
        return (int'(a[1:0]) + model_n(f3) > 4) ? 3 : 2;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        int n = model_n(f3);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < n; i++)
            v = v | (64'(ref_mem[14'(a + 32'(i))]) << (8 * i));
        if (!f3[2] && v[8*n-1])
            v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v[31:0];
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
        for (int i = 0; i < model_n(f3); i++)
            ref_mem[14'(a + 32'(i))] = wd[8*i +: 8];
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] m);
        logic [31:0] r = 32'd0;
        for (int k = 0; k < 4; k++)
            if (m[k]) r[8*k +: 8] = 8'hFF;
        return r;
    endfunction

    typedef struct {
        logic [AW-1:0] a;
        logic          we;
        logic [3:0]    m;
        logic [31:0]   d;
    } obs_t;
    obs_t obs[$];

    // Issue one request and wait (bounded) for its response pulse. Latency
    // counts clock edges from the accept edge to the respValid cycle.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic er, output int lat);
        bit got = 1'b0;
        obs.delete();
        rd = 32'd0;
        er = 1'b0;
        lat = 0;
        @(negedge clock);
        check("req_ready_idle", 64'(reqReady), 64'd1);
        reqValid = 1'b1; reqWrite = w; reqFunct3 = f3; reqAddress = a; reqWriteData = wd;
        @(posedge clock);
        #1;
        // Scramble request lines so only latched values can be used.
        reqValid = 1'b0; reqWrite = ~w; reqFunct3 = 3'($urandom);
        reqAddress = $urandom; reqWriteData = $urandom;
        while (!got && lat < 8) begin
            @(negedge clock);
            lat++;
            obs.push_back('{sramAddress, sramWriteEnable, sramByteWriteMask, sramWrite});
            if (respValid) begin
                got = 1'b1;
                rd = respReadData;
                er = respError;
            end
        end
        check("resp_seen", 64'(got), 64'd1);
        @(negedge clock);
        check("resp_single_pulse", 64'(respValid), 64'd0);
    endtask

    // Request checked against the reference model, which is then updated.
    task automatic run_model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input string tag);
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          ill = model_illegal(w, f3);
        logic [31:0] exp_d = (w || ill) ? 32'd0 : model_load(a, f3);
        do_req(w, f3, a, wd, rd, er, lat);
        check({tag, "_data"}, 64'(rd), 64'(exp_d));
        check({tag, "_err"}, 64'(er), 64'(ill));
        check({tag, "_lat"}, 64'(lat), 64'(model_lat(w, f3, a)));
        if (w && !ill) model_store(a, f3, wd);
    endtask

    typedef struct {
        logic          write;
        logic [2:0]    f3;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [31:0]   exp_data;
        logic          exp_err;
        int            exp_lat;
        logic          chk;
        logic [AW-1:0] a0;
        logic [3:0]    m0;
        logic [31:0]   d0;
        logic [AW-1:0] a1;
        logic [3:0]    m1;
        logic [31:0]   d1;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          mism;
        logic [31:0] ra;
        logic [2:0]  rf;
        logic        rw;

        //           w  f3      addr        wdata         exp_data      err lat chk a0      m0     d0            a1      m1     d1
        vecs[0]  = '{1, 3'b010, 32'h10,     32'hDEADBEEF, 32'h0,        0,  2,  1,  12'h004, 4'hF, 32'hDEADBEEF, 12'h0,   4'h0, 32'h0};
        vecs[1]  = '{0, 3'b010, 32'h10,     32'h0,        32'hDEADBEEF, 0,  2,  1,  12'h004, 4'hF, 32'h0,        12'h0,   4'h0, 32'h0};
        vecs[2]  = '{1, 3'b000, 32'h13,     32'h000000AB, 32'h0,        0,  2,  1,  12'h004, 4'h8, 32'hAB000000, 12'h0,   4'h0, 32'h0};
        vecs[3]  = '{0, 3'b000, 32'h13,     32'h0,        32'hFFFFFFAB, 0,  2,  0,  12'h0,   4'h0, 32'h0,        12'h0,   4'h0, 32'h0};
        vecs[4]  = '{0, 3'b100, 32'h13,     32'h0,        32'h000000AB, 0,  2,  0,  12'h0,   4'h0, 32'h0,        12'h0,   4'h0, 32'h0};
        vecs[5]  = '{1, 3'b001, 32'h17,     32'h00001234, 32'h0,        0,  3,  1,  12'h005, 4'h8, 32'h34000000, 12'h006, 4'h1, 32'h00000012};
        vecs[6]  = '{0, 3'b001, 32'h17,     32'h0,        32'h00001234, 0,  3,  1,  12'h005, 4'h8, 32'h0,        12'h006, 4'h1, 32'h0};
        vecs[7]  = '{1, 3'b001, 32'h02,     32'hFFFF8001, 32'h0,        0,  2,  1,  12'h000, 4'hC, 32'h80010000, 12'h0,   4'h0, 32'h0};
        vecs[8]  = '{0, 3'b001, 32'h02,     32'h0,        32'hFFFF8001, 0,  2,  0,  12'h0,   4'h0, 32'h0,        12'h0,   4'h0, 32'h0};
        vecs[9]  = '{0, 3'b101, 32'h02,     32'h0,        32'h00008001, 0,  2,  0,  12'h0,   4'h0, 32'h0,        12'h0,   4'h0, 32'h0};
        vecs[10] = '{0, 3'b011, 32'h40,     32'h0,        32'h0,        1,  1,  0,  12'h0,   4'h0, 32'h0,        12'h0,   4'h0, 32'h0};
        vecs[11] = '{1, 3'b110, 32'h44,     32'h12345678, 32'h0,        1,  1,  0,  12'h0,   4'h0, 32'h0,        12'h0,   4'h0, 32'h0};
        vecs[12] = '{0, 3'b010, 32'h44,     32'h0,        32'h0,        0,  2,  0,  12'h0,   4'h0, 32'h0,        12'h0,   4'h0, 32'h0};
        vecs[13] = '{1, 3'b010, 32'h3FFC,   32'h44332211, 32'h0,        0,  2,  1,  12'hFFF, 4'hF, 32'h44332211, 12'h0,   4'h0, 32'h0};
        vecs[14] = '{1, 3'b010, 32'h0,      32'h88776655, 32'h0,        0,  2,  1,  12'h000, 4'hF, 32'h88776655, 12'h0,   4'h0, 32'h0};
        vecs[15] = '{0, 3'b010, 32'h3FFE,   32'h0,        32'h66554433, 0,  3,  1,  12'hFFF, 4'hC, 32'h0,        12'h000, 4'h3, 32'h0};
        vecs[16] = '{0, 3'b010, 32'h11,     32'h0,        32'h00ABADBE, 0,  3,  1,  12'h004, 4'hE, 32'h0,        12'h005, 4'h1, 32'h0};

        reqValid = 1'b0; reqWrite = 1'b0; reqFunct3 = 3'd0;
        reqAddress = 32'd0; reqWriteData = 32'd0;

        // Reset values.
        #2 reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_req_ready", 64'(reqReady), 64'd1);
        check("rst_resp", 64'({respValid, respError, respReadData}), 64'd0);
        check("rst_sram", 64'({sramAddress, sramWriteEnable, sramByteWriteMask, sramWrite}), 64'd0);
        reset = 1'b0;

        // Directed table.
        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i].write, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            check($sformatf("vec%0d_data", i), 64'(rd), 64'(vecs[i].exp_data));
            check($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_resp_sram_quiet", i),
                  64'({obs[$].a, obs[$].m, obs[$].we, obs[$].d}), 64'd0);
            if (vecs[i].exp_err) begin
                foreach (obs[j])
                    check($sformatf("vec%0d_illegal_no_we", i), 64'(obs[j].we), 64'd0);
            end
            if (vecs[i].chk && obs.size() >= 2) begin
                check($sformatf("vec%0d_a0", i), 64'(obs[0].a), 64'(vecs[i].a0));
                check($sformatf("vec%0d_m0", i), 64'(obs[0].m), 64'(vecs[i].m0));
                check($sformatf("vec%0d_we0", i), 64'(obs[0].we), 64'(vecs[i].write));
                if (vecs[i].write)
                    check($sformatf("vec%0d_d0", i), 64'(obs[0].d & lanes(vecs[i].m0)), 64'(vecs[i].d0));
                if (vecs[i].exp_lat == 3) begin
                    check($sformatf("vec%0d_a1", i), 64'(obs[1].a), 64'(vecs[i].a1));
                    check($sformatf("vec%0d_m1", i), 64'(obs[1].m), 64'(vecs[i].m1));
                    check($sformatf("vec%0d_we1", i), 64'(obs[1].we), 64'(vecs[i].write));
                    if (vecs[i].write)
                        check($sformatf("vec%0d_d1", i), 64'(obs[1].d & lanes(vecs[i].m1)), 64'(vecs[i].d1));
                end
            end
            if (vecs[i].write && !vecs[i].exp_err)
                model_store(vecs[i].addr, vecs[i].f3, vecs[i].wdata);
        end

        // Reset in the middle of the second half of a split store.
        run_model(1'b1, 3'b010, 32'h20, 32'h11111111, "pre_w8");
        run_model(1'b1, 3'b010, 32'h24, 32'h22222222, "pre_w9");
        @(negedge clock);
        reqValid = 1'b1; reqWrite = 1'b1; reqFunct3 = 3'b010;
        reqAddress = 32'h21; reqWriteData = 32'hCAFEF00D;
        @(posedge clock);
        #1 reqValid = 1'b0;
        @(posedge clock);
        #1;
        check("rst6_in_second_addr", 64'(sramAddress), 64'd9);
        reset = 1'b1;
        #1;
        check("rst6_sram_zero", 64'({sramAddress, sramWriteEnable, sramByteWriteMask, sramWrite}), 64'd0);
        check("rst6_resp_zero", 64'({respValid, respError, respReadData}), 64'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst6_ready_after", 64'(reqReady), 64'd1);
        check("rst6_word8", 64'(sram_mem[8]), 64'h00000000FEF00D11);
        check("rst6_word9", 64'(sram_mem[9]), 64'h0000000022222222);
        // Only the w0 half (bytes 0x21..0x23) reached the SRAM.
        ref_mem[14'h21] = 8'h0D;
        ref_mem[14'h22] = 8'hF0;
        ref_mem[14'h23] = 8'hFE;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            rw = 1'($urandom_range(0, 1));
            rf = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) rf[1:0] = 2'($urandom_range(0, 2));
            case ($urandom_range(0, 3))
                0:       ra = $urandom;
                1:       ra = ($urandom << 14) | (32'h3FF8 + 32'($urandom_range(0, 7)));
                default: ra = 32'($urandom_range(0, 63));
            endcase
            run_model(rw, rf, ra, $urandom, $sformatf("rnd%0d", i));
        end

        // Whole-memory image against the reference.
        mism = 0;
        for (int w = 0; w < NWORDS; w++)
            if (sram_mem[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]})
                mism++;
        check("mem_image_diff_words", 64'(mism), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
